// File: rtl/bin2ascii_seq_pkg.sv
// Shared constants for the binary-to-ASCII text path.
//   ASCII_ZERO / ASCII_NINE / ASCII_SPACE : character codes used by the formatter
//   state_t                               : converter FSM state encoding
package bin2ascii_seq_pkg;

  localparam logic [6:0] ASCII_ZERO  = 7'h30;
  localparam logic [6:0] ASCII_NINE  = 7'h39;
  localparam logic [6:0] ASCII_SPACE = 7'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FMT  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2ascii_seq_bcd_add3.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
//   din  : 4-bit BCD digit before adjust
//   dout : adjusted digit
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2ascii_seq.sv
// Sequential binary-to-ASCII decimal converter (shift-add-3), with optional
// leading-zero blanking and saturation to "99..9" on overflow.
//   clk, rst : clock, synchronous active-high reset
//   start    : conversion request, accepted only while idle
//   value    : unsigned binary input, captured on the accepting edge
//   busy     : conversion in progress
//   done     : one-cycle pulse when ascii/overflow update
//   ascii    : DIGITS packed 7-bit characters, units in [6:0]
//   overflow : last completed value did not fit in DIGITS digits
//
// state | meaning
// IDLE  | waiting for start, outputs hold
// CONV  | one input bit shifted into the BCD register per cycle
// FMT   | BCD digits turned into characters, done pulsed
module bin2ascii_seq
  import bin2ascii_seq_pkg::*;
#(
  parameter int         IN_W       = 16,
  parameter int         DIGITS     = 5,
  parameter int         BLANK_LZ   = 1,
  parameter logic [6:0] BLANK_CHAR = ASCII_SPACE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   ascii,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t                 state_q, state_d;
  logic [IN_W-1:0]        shift_q, shift_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [7*DIGITS-1:0]    ascii_q, ascii_d;
  logic                   overflow_q, overflow_d;
  logic                   done_q, done_d;
  logic [7*DIGITS-1:0]    ascii_fmt;
  logic [7*DIGITS-1:0]    ascii_rst;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Formatted value 0: units '0', everything above blank (or '0').
  always_comb begin
    ascii_rst = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k != 0 && BLANK_LZ != 0) ascii_rst[7*k +: 7] = BLANK_CHAR;
      else                          ascii_rst[7*k +: 7] = ASCII_ZERO;
    end
  end

  // Walk from the top digit down; blanking stops at the first nonzero digit,
  // so interior zeros are always printed.
  always_comb begin
    logic       seen_nz;
    logic [3:0] dig;
    ascii_fmt = '0;
    seen_nz   = 1'b0;
    dig       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig = bcd_q[4*k +: 4];
      if (dig != 4'd0) seen_nz = 1'b1;
      if (BLANK_LZ != 0 && !seen_nz && k != 0) ascii_fmt[7*k +: 7] = BLANK_CHAR;
      else                                     ascii_fmt[7*k +: 7] = ASCII_ZERO + {3'b000, dig};
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    ascii_d    = ascii_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = value;
          bcd_d   = '0;
          cnt_d   = CNT_W'(IN_W);
          ovf_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        // A bit leaving the top digit means the value needs more digits.
        ovf_d = ovf_q | bcd_adj[BCD_W-1];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FMT;
      end
      FMT: begin
        if (ovf_q) begin
          ascii_d    = {DIGITS{ASCII_NINE}};
          overflow_d = 1'b1;
        end else begin
          ascii_d    = ascii_fmt;
          overflow_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ascii_q    <= ascii_rst;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ascii_q    <= ascii_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ascii    = ascii_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2ascii_seq.sv
module tb_bin2ascii_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] value;

  logic        busy_a, done_a, ovf_a;
  logic [34:0] ascii_a;
  logic        busy_b, done_b, ovf_b;
  logic [27:0] ascii_b;
  logic        busy_c, done_c, ovf_c;
  logic [34:0] ascii_c;

  int checks = 0;
  int errors = 0;

  logic [35:0] q_a[$];
  logic [35:0] q_b[$];
  logic [35:0] q_c[$];

  always #5 clk = ~clk;

  bin2ascii_seq #(.IN_W(16), .DIGITS(5), .BLANK_LZ(1), .BLANK_CHAR(7'h20)) u_a (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_a), .done(done_a), .ascii(ascii_a), .overflow(ovf_a));

  bin2ascii_seq #(.IN_W(16), .DIGITS(4), .BLANK_LZ(1), .BLANK_CHAR(7'h20)) u_b (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_b), .done(done_b), .ascii(ascii_b), .overflow(ovf_b));

  bin2ascii_seq #(.IN_W(16), .DIGITS(5), .BLANK_LZ(0), .BLANK_CHAR(7'h20)) u_c (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_c), .done(done_c), .ascii(ascii_c), .overflow(ovf_c));

  // Reference: {overflow, chars} built with plain division.
  function automatic logic [35:0] model(input int v, input int nd, input bit blz);
    logic [34:0] a;
    int p;
    a = '0;
    p = 1;
    for (int k = 0; k < nd; k++) p = p * 10;
    if (v >= p) begin
      for (int k = 0; k < nd; k++) a[7*k +: 7] = 7'h39;
      return {1'b1, a};
    end
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (blz && k > 0 && v < p) a[7*k +: 7] = 7'h20;
      else                       a[7*k +: 7] = 7'(48 + (v / p) % 10);
      p = p * 10;
    end
    return {1'b0, a};
  endfunction

  // Scoreboard monitors: each done pops one expectation per instance.
  always @(negedge clk) begin
    logic [35:0] e;
    if (done_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL sb_a_unexpected_done ascii=%h ovf=%b", ascii_a, ovf_a);
      end else begin
        e = q_a.pop_front();
        if ({ovf_a, ascii_a} !== e) begin
          errors++;
          $display("FAIL sb_a got ovf=%b ascii=%h want ovf=%b ascii=%h", ovf_a, ascii_a, e[35], e[34:0]);
        end
      end
    end
    if (done_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL sb_b_unexpected_done ascii=%h ovf=%b", ascii_b, ovf_b);
      end else begin
        e = q_b.pop_front();
        if ({ovf_b, ascii_b} !== {e[35], e[27:0]}) begin
          errors++;
          $display("FAIL sb_b got ovf=%b ascii=%h want ovf=%b ascii=%h", ovf_b, ascii_b, e[35], e[27:0]);
        end
      end
    end
    if (done_c) begin
      checks++;
      if (q_c.size() == 0) begin
        errors++;
        $display("FAIL sb_c_unexpected_done ascii=%h ovf=%b", ascii_c, ovf_c);
      end else begin
        e = q_c.pop_front();
        if ({ovf_c, ascii_c} !== e) begin
          errors++;
          $display("FAIL sb_c got ovf=%b ascii=%h want ovf=%b ascii=%h", ovf_c, ascii_c, e[35], e[34:0]);
        end
      end
    end
  end

  task automatic push_exp(input int v);
    q_a.push_back(model(v, 5, 1'b1));
    q_b.push_back(model(v, 4, 1'b1));
    q_c.push_back(model(v, 5, 1'b0));
  endtask

  // Starts one conversion and returns edges from acceptance to done plus
  // the number of sampled cycles with busy high. Bounded at 40 cycles.
  task automatic do_conv(input int v, output int lat, output int bc);
    push_exp(v);
    value = 16'(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bc  = 0;
    while (!done_a && lat < 40) begin
      if (busy_a) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; value = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({busy_a, done_a, ovf_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got busy=%b done=%b ovf=%b want 000", busy_a, done_a, ovf_a);
    end
    checks++;
    if (ascii_a !== {7'h20, 7'h20, 7'h20, 7'h20, 7'h30}) begin
      errors++;
      $display("FAIL reset_ascii_a got %h want %h", ascii_a, {7'h20, 7'h20, 7'h20, 7'h20, 7'h30});
    end
    checks++;
    if (ascii_c !== {5{7'h30}}) begin
      errors++;
      $display("FAIL reset_ascii_c got %h want %h", ascii_c, {5{7'h30}});
    end
  endtask

  task automatic test_zero;
    int lat, bc;
    do_conv(0, lat, bc);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL zero_latency got %0d want 17", lat);
    end
  endtask

  task automatic test_basic;
    int lat, bc;
    do_conv(12345, lat, bc);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL basic_latency got %0d want 17", lat);
    end
    checks++;
    if (bc !== 17) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 17", bc);
    end
    checks++;
    if (ascii_a !== {7'h31, 7'h32, 7'h33, 7'h34, 7'h35}) begin
      errors++;
      $display("FAIL basic_ascii got %h want %h", ascii_a, {7'h31, 7'h32, 7'h33, 7'h34, 7'h35});
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done got %b want 0", busy_a);
    end
  endtask

  task automatic test_overflow;
    int lat, bc;
    do_conv(65535, lat, bc);
    checks++;
    if ({ovf_b, ascii_b} !== {1'b1, {4{7'h39}}}) begin
      errors++;
      $display("FAIL ovf_sat got ovf=%b ascii=%h want 1 %h", ovf_b, ascii_b, {4{7'h39}});
    end
    do_conv(42, lat, bc);
    checks++;
    if ({ovf_b, ascii_b} !== {1'b0, 7'h20, 7'h20, 7'h34, 7'h32}) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%b ascii=%h want 0 %h", ovf_b, ascii_b, {7'h20, 7'h20, 7'h34, 7'h32});
    end
    do_conv(9999, lat, bc);
    do_conv(10000, lat, bc);
    checks++;
    if (ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_boundary got %b want 1", ovf_b);
    end
  endtask

  task automatic test_blanking;
    int lat, bc;
    do_conv(7, lat, bc);
    checks++;
    if (ascii_c !== {7'h30, 7'h30, 7'h30, 7'h30, 7'h37}) begin
      errors++;
      $display("FAIL noblank_7 got %h want %h", ascii_c, {7'h30, 7'h30, 7'h30, 7'h30, 7'h37});
    end
    do_conv(100, lat, bc);
    checks++;
    if (ascii_c !== {7'h30, 7'h30, 7'h31, 7'h30, 7'h30}) begin
      errors++;
      $display("FAIL noblank_100 got %h want %h", ascii_c, {7'h30, 7'h30, 7'h31, 7'h30, 7'h30});
    end
    checks++;
    if (ascii_a !== {7'h20, 7'h20, 7'h31, 7'h30, 7'h30}) begin
      errors++;
      $display("FAIL blank_100 got %h want %h", ascii_a, {7'h20, 7'h20, 7'h31, 7'h30, 7'h30});
    end
    for (int i = 0; i < 4; i++) do_conv(int'($urandom_range(0, 65535)), lat, bc);
  endtask

  task automatic test_ignore_start;
    int lat, dones;
    push_exp(321);
    value = 16'd321;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    value = 16'd999;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    value = 16'd5555;
    lat = 6; dones = 0;
    while (lat < 40) begin
      if (done_a) dones++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d want 1", dones);
    end
    checks++;
    if (ascii_a !== {7'h20, 7'h20, 7'h33, 7'h32, 7'h31}) begin
      errors++;
      $display("FAIL ignore_result got %h want %h", ascii_a, {7'h20, 7'h20, 7'h33, 7'h32, 7'h31});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    push_exp(500);
    value = 16'd500;
    start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d want 17", lat);
    end
    push_exp(777);
    value = 16'd777;
    @(posedge clk); #1;
    start = 1'b0;
    value = 16'd1;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept got busy=%b want 1", busy_a);
    end
    lat = 0;
    while (!done_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL b2b_second_latency got %0d want 17", lat);
    end
  endtask

  task automatic test_reset_abort;
    int lat, bc, dones;
    value = 16'd999;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      errors++;
      $display("FAIL abort_flags got busy=%b done=%b want 00", busy_a, done_a);
    end
    checks++;
    if (ascii_a !== {7'h20, 7'h20, 7'h20, 7'h20, 7'h30}) begin
      errors++;
      $display("FAIL abort_ascii got %h want %h", ascii_a, {7'h20, 7'h20, 7'h20, 7'h20, 7'h30});
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_a) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d want 0", dones);
    end
    do_conv(999, lat, bc);
    checks++;
    if (ascii_a !== {7'h20, 7'h20, 7'h39, 7'h39, 7'h39}) begin
      errors++;
      $display("FAIL abort_restart got %h want %h", ascii_a, {7'h20, 7'h20, 7'h39, 7'h39, 7'h39});
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_overflow();
    test_blanking();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", q_a.size() + q_b.size() + q_c.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2ascii_seq.md
Name: bin2ascii_seq

Overview:
Parametrised sequential binary-to-ASCII decimal converter for on-screen score, counter and timer text. It replaces fixed 2-digit, 0..99 conversion with a configurable input width and digit count. Conversion uses an iterative shift-add-3 (double-dabble) core with a start/busy/done handshake. It adds optional leading-zero blanking and overflow saturation. It sits between game/score logic and the character-ROM text renderer.

Parameters:
IN_W, 16, binary input width in bits (>=2)
DIGITS, 5, number of decimal output characters (>=1)
BLANK_LZ, 1, 1 = replace leading zeros with BLANK_CHAR; the least-significant digit is never blanked
BLANK_CHAR, 7'h20, 7-bit ASCII code used for blanked positions

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  request conversion of value; sampled only when busy=0
value  in  IN_W  unsigned binary input, captured on an accepted start
busy  out  1  high while a conversion is in progress
done  out  1  single-cycle pulse when ascii/overflow are updated
ascii  out  7*DIGITS  packed characters; digit 0 (units) in [6:0], digit k in [7k+6:7k]
overflow  out  1  value >= 10^DIGITS for the last completed conversion

Behaviour:
- Reset: state=IDLE, busy=0, done=0, overflow=0. ascii = formatted value 0, i.e. units char 7'h30. Other chars are BLANK_CHAR if BLANK_LZ=1, else 7'h30.
- Reset mid-conversion aborts immediately. The partially converted result is discarded and never output.
- State IDLE: busy=0. If start=1, latch value into a shift register, clear the BCD register and sticky overflow flag, load bit counter = IN_W, and go to CONV.
- State CONV: busy=1. One bit per cycle:
  - Each BCD digit >= 5 gets +3.
  - Then {bcd, shift} shifts left by 1, MSB of the shift register entering bcd LSB.
  - A 1 shifted out of the top BCD digit sets sticky overflow.
  - Counter decrements; after the IN_W-th shift go to FMT.
- State FMT: busy=1, one cycle.
  - If overflow: ascii = DIGITS x 7'h39 ("99...9"), overflow<=1, no blanking.
  - Else: each digit d maps to 7'h30+d. If BLANK_LZ, blank every digit above the highest nonzero digit, and always keep the units digit.
  - Register outputs, pulse done=1, go to IDLE with busy=0.
- Latency: start accepted at edge N, outputs and done valid after edge N+IN_W+1. Throughput: one conversion per IN_W+2 cycles, since start is accepted again in the cycle after done.
- start while busy=1 is ignored, with no queuing. start held high re-triggers on each return to IDLE.
- value is sampled only on the accepting edge; later changes do not affect the result.
- ascii and overflow hold their values between done pulses.
- Width rules:
  - BCD register is 4*DIGITS bits.
  - No digit ever exceeds 9 after adjustment.
  - If DIGITS >= ceil(IN_W*log10(2)), overflow is structurally impossible; implementation may leave the logic in place.
  - The counter is $clog2(IN_W+1) bits.

Decomposition:
- Shared package/include (text_pkg): ASCII_ZERO=7'h30, ASCII_NINE=7'h39, ASCII_SPACE=7'h20, and the state encoding localparams IDLE/CONV/FMT.
- One natural sub-module, bcd_add3: a 4-bit combinational digit adjust (d>=5 ? d+3 : d). It is instantiated DIGITS times in a generate loop.
- FSM, shift datapath and formatting stay in the top.

Test Plan:
Use IN_W=16, DIGITS=5, BLANK_LZ=1 unless stated.
1. Reset, then start with value=0 -> done 17 cycles later; ascii="    0" (20,20,20,20,30); overflow=0.
2. value=12345 -> ascii="12345"; done exactly 17 cycles after the start edge; busy high for 17 cycles.
3. value=65535 with DIGITS=4 -> ascii="9999", overflow=1. Then value=42 -> "  42", overflow=0.
4. BLANK_LZ=0, value=7 -> "00007". value=100 -> "00100", with interior zeros never blanked in either mode.
5. Pulse start at cycle 5 of a conversion with a different value -> ignored; the first result is unchanged and only one done pulse occurs.
6. Assert rst at cycle 8 of a conversion of 999 -> busy=0 and ascii=reset value next cycle, no done pulse. A fresh start then gives "  999".
